// File: rtl/pwm_led_peripheral.sv
// Memory-mapped four-channel PWM peripheral for the board LED and RGB pins.
// Duty writes land in pending registers and reach the comparators only at the 255->0 wrap.
module pwm_led_peripheral #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00,
  parameter int unsigned PRESCALE  = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_wen,
  input  logic        mem_ren,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_rvalid,
  output logic        led,
  output logic        red,
  output logic        green,
  output logic        blue
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);
  localparam int NCH = 4;

  typedef enum logic [2:0] {
    OFF_CTRL  = 3'd0,
    OFF_LED   = 3'd1,
    OFF_RED   = 3'd2,
    OFF_GREEN = 3'd3,
    OFF_BLUE  = 3'd4,
    OFF_COUNT = 3'd5,
    OFF_RSV6  = 3'd6,
    OFF_RSV7  = 3'd7
  } reg_off_e;

  logic           in_range;
  reg_off_e       off;
  logic           wr_en;
  logic           rd_en;
  logic           en;
  logic           en_next;
  logic [PW-1:0]  presc;
  logic [7:0]     pwm_cnt;
  logic           tick;
  logic           wrap;
  logic [NCH-1:0] ch_wr;
  logic [NCH-1:0] ch_out;
  logic [7:0]     pending_duty [NCH];
  logic [7:0]     active_duty  [NCH];
  logic [31:0]    rd_value;
  logic           unused_bits;

  assign in_range = (mem_addr[31:5] == BASE_ADDR[31:5]);
  assign off      = reg_off_e'(mem_addr[4:2]);
  assign wr_en    = mem_wen && in_range;
  assign rd_en    = mem_ren && in_range;

  // Byte-lane and upper data bits carry no state here.
  assign unused_bits = ^{mem_addr[1:0], mem_wdata[31:8]};

  assign tick = en && (presc == PS_LAST);
  assign wrap = tick && (pwm_cnt == 8'hFF);

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    en_next = en;
    if (wr_en && (off == OFF_CTRL)) en_next = mem_wdata[0];
  end

  always_comb begin
    ch_wr = '0;
    for (int i = 0; i < NCH; i++) begin
      ch_wr[i] = wr_en && (off == reg_off_e'(3'(i + 1)));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en      <= 1'b0;
      presc   <= '0;
      pwm_cnt <= 8'd0;
    end else begin
      en <= en_next;
      // A disabling write clears the counters on the same edge that latches EN=0.
      if (!en_next) begin
        presc   <= '0;
        pwm_cnt <= 8'd0;
      end else if (tick) begin
        presc   <= '0;
        pwm_cnt <= pwm_cnt + 8'd1;
      end else if (en) begin
        presc <= presc + PW'(1);
      end
    end
  end

  // NOTE: the small duty arrays are register files, not RAM, so they take the async reset too.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCH; i++) begin
        pending_duty[i] <= 8'd0;
        active_duty[i]  <= 8'd0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        // Load uses the pre-write pending value, so a write on the wrap edge waits a full period.
        if (!en || wrap) active_duty[i] <= pending_duty[i];
        if (ch_wr[i])    pending_duty[i] <= mem_wdata[7:0];
      end
    end
  end

  // Gating on both en and en_next keeps the enable edge and the disable edge low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ch_out <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        ch_out[i] <= en && en_next && (pwm_cnt < active_duty[i]);
      end
    end
  end

  assign led   = ch_out[0];
  assign red   = ch_out[1];
  assign green = ch_out[2];
  assign blue  = ch_out[3];

  always_comb begin
    rd_value = 32'd0;
    case (off)
      OFF_CTRL:  rd_value = {31'd0, en};
      OFF_LED:   rd_value = {24'd0, pending_duty[0]};
      OFF_RED:   rd_value = {24'd0, pending_duty[1]};
      OFF_GREEN: rd_value = {24'd0, pending_duty[2]};
      OFF_BLUE:  rd_value = {24'd0, pending_duty[3]};
      OFF_COUNT: rd_value = {24'd0, pwm_cnt};
      default:   rd_value = 32'd0;
    endcase
  end

  // Read data is captured before this edge's writes land, so a same-cycle write+read sees the old value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_rvalid <= 1'b0;
      mem_rdata  <= 32'd0;
    end else begin
      mem_rvalid <= rd_en;
      mem_rdata  <= rd_en ? rd_value : 32'd0;
    end
  end

endmodule
